// File: rtl/instr_pkg.sv
// Shared instruction-set constants: mnemonic codes, MIPS opcode/funct values
// and the program-load engine state encoding.
package instr_pkg;

   localparam int MNEM_BITS = 6;

   // Codes 33..63 are unassigned and treated as illegal by the encoder.
   typedef enum logic [MNEM_BITS-1:0] {
      MN_ADD   = 6'd0,  MN_ADDU  = 6'd1,  MN_SUB   = 6'd2,  MN_SUBU  = 6'd3,
      MN_AND   = 6'd4,  MN_OR    = 6'd5,  MN_XOR   = 6'd6,  MN_NOR   = 6'd7,
      MN_SLT   = 6'd8,  MN_SLTU  = 6'd9,  MN_SLL   = 6'd10, MN_SRL   = 6'd11,
      MN_SRA   = 6'd12, MN_JR    = 6'd13, MN_BEQ   = 6'd14, MN_BNE   = 6'd15,
      MN_ADDI  = 6'd16, MN_ADDIU = 6'd17, MN_SLTI  = 6'd18, MN_SLTIU = 6'd19,
      MN_ORI   = 6'd20, MN_XORI  = 6'd21, MN_LUI   = 6'd22, MN_LB    = 6'd23,
      MN_LH    = 6'd24, MN_LW    = 6'd25, MN_LBU   = 6'd26, MN_LHU   = 6'd27,
      MN_SB    = 6'd28, MN_SH    = 6'd29, MN_SW    = 6'd30, MN_J     = 6'd31,
      MN_JAL   = 6'd32
   } mnem_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      FMT_R,
      FMT_I,
      FMT_J
   } fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WRITE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational encoder: mnemonic plus raw fields to a 32-bit MIPS word,
// with field masking and a legal flag for unassigned mnemonic codes.
module instr_field_packer import instr_pkg::*; #(
   parameter int MNEM_W = 6
) (
   input  logic [MNEM_W-1:0] mnem,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic [31:0]       word,
   output logic              legal
);

   fmt_t       fmt;
   logic [5:0] op;
   logic [5:0] funct;
   logic       is_shift;
   logic       is_jr;
   logic       is_lui;

   always_comb begin
      legal    = 1'b1;
      fmt      = FMT_R;
      op       = OP_RTYPE;
      funct    = 6'h00;
      is_shift = 1'b0;
      is_jr    = 1'b0;
      is_lui   = 1'b0;
      case (mnem)
         MN_ADD:   funct = FN_ADD;
         MN_ADDU:  funct = FN_ADDU;
         MN_SUB:   funct = FN_SUB;
         MN_SUBU:  funct = FN_SUBU;
         MN_AND:   funct = FN_AND;
         MN_OR:    funct = FN_OR;
         MN_XOR:   funct = FN_XOR;
         MN_NOR:   funct = FN_NOR;
         MN_SLT:   funct = FN_SLT;
         MN_SLTU:  funct = FN_SLTU;
         MN_SLL:   begin funct = FN_SLL; is_shift = 1'b1; end
         MN_SRL:   begin funct = FN_SRL; is_shift = 1'b1; end
         MN_SRA:   begin funct = FN_SRA; is_shift = 1'b1; end
         MN_JR:    begin funct = FN_JR;  is_jr    = 1'b1; end
         MN_BEQ:   begin fmt = FMT_I; op = OP_BEQ;   end
         MN_BNE:   begin fmt = FMT_I; op = OP_BNE;   end
         MN_ADDI:  begin fmt = FMT_I; op = OP_ADDI;  end
         MN_ADDIU: begin fmt = FMT_I; op = OP_ADDIU; end
         MN_SLTI:  begin fmt = FMT_I; op = OP_SLTI;  end
         MN_SLTIU: begin fmt = FMT_I; op = OP_SLTIU; end
         MN_ORI:   begin fmt = FMT_I; op = OP_ORI;   end
         MN_XORI:  begin fmt = FMT_I; op = OP_XORI;  end
         MN_LUI:   begin fmt = FMT_I; op = OP_LUI; is_lui = 1'b1; end
         MN_LB:    begin fmt = FMT_I; op = OP_LB;    end
         MN_LH:    begin fmt = FMT_I; op = OP_LH;    end
         MN_LW:    begin fmt = FMT_I; op = OP_LW;    end
         MN_LBU:   begin fmt = FMT_I; op = OP_LBU;   end
         MN_LHU:   begin fmt = FMT_I; op = OP_LHU;   end
         MN_SB:    begin fmt = FMT_I; op = OP_SB;    end
         MN_SH:    begin fmt = FMT_I; op = OP_SH;    end
         MN_SW:    begin fmt = FMT_I; op = OP_SW;    end
         MN_J:     begin fmt = FMT_J; op = OP_J;     end
         MN_JAL:   begin fmt = FMT_J; op = OP_JAL;   end
         default:  legal = 1'b0;
      endcase
   end

   // Unused fields are zeroed so the memory image is canonical.
   always_comb begin
      word = 32'h0;
      if (legal) begin
         case (fmt)
            FMT_R: word = {OP_RTYPE,
                           is_shift ? 5'd0 : rs,
                           is_jr    ? 5'd0 : rt,
                           is_jr    ? 5'd0 : rd,
                           is_shift ? shamt : 5'd0,
                           funct};
            FMT_I: word = {op, is_lui ? 5'd0 : rs, rt, imm};
            FMT_J: word = {op, target};
            default: word = 32'h0;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Program-load engine: accepts symbolic instruction requests, encodes them and
// writes each word to instruction memory at an auto-incrementing address.
module instr_encoder import instr_pkg::*; #(
   parameter int ADDR_W = 12,
   parameter int MNEM_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MNEM_W-1:0] in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   input  logic              im_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] count,
   output state_t            dbg_state
);

   // Handshakes: a request transfers on a rising edge where in_valid and
   // in_ready are both high; a memory write completes on a rising edge where
   // im_we and im_ack are both high, and im_addr/im_wdata hold until then.

   state_t      state;
   state_t      state_next;
   logic [31:0] pk_word;
   logic        pk_legal;
   logic        last_q;
   logic        start_ok;

   instr_field_packer #(.MNEM_W(MNEM_W)) u_packer (
      .mnem   (in_mnem),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .shamt  (in_shamt),
      .imm    (in_imm),
      .target (in_target),
      .word   (pk_word),
      .legal  (pk_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_ACCEPT;
         ST_ACCEPT: begin
            if (in_valid) begin
               if (pk_legal)     state_next = ST_WRITE;
               else if (in_last) state_next = ST_DONE;
            end
         end
         ST_WRITE:  if (im_ack) state_next = last_q ? ST_DONE : ST_ACCEPT;
         ST_DONE:   state_next = start ? ST_ACCEPT : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
   assign in_ready  = (state == ST_ACCEPT);
   assign im_we     = (state == ST_WRITE);
   assign busy      = (state == ST_ACCEPT) || (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign dbg_state = state;

   // Address and count wrap naturally at ADDR_W bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im_addr  <= '0;
         im_wdata <= 32'h0;
         count    <= '0;
         err      <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         if (start_ok) begin
            im_addr <= {base_addr[ADDR_W-1:2], 2'b00};
            count   <= '0;
            err     <= 1'b0;
         end
         if (state == ST_ACCEPT && in_valid) begin
            if (pk_legal) begin
               im_wdata <= pk_word;
               last_q   <= in_last;
            end else begin
               err <= 1'b1;
            end
         end
         if (state == ST_WRITE && im_ack) begin
            im_addr <= im_addr + ADDR_W'(4);
            count   <= count + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, handshake latency, stalls,
// illegal mnemonics, reset mid-write and address wrap.
module tb_instr_encoder;
   import instr_pkg::*;

   localparam int ADDR_W = 12;
   localparam int MNEM_W = 6;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [MNEM_W-1:0] in_mnem;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              in_last;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              im_ack;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] count;
   state_t            dbg_state;

   int checks = 0;
   int failures = 0;
   logic [ADDR_W+32-1:0] exp_q[$];

   instr_encoder #(.ADDR_W(ADDR_W), .MNEM_W(MNEM_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mnem   (in_mnem),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_imm    (in_imm),
      .in_target (in_target),
      .in_last   (in_last),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .im_ack    (im_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .count     (count),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $fatal(1, "FAIL watchdog timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] base);
      start     = 1'b1;
      base_addr = base;
      tick;
      start     = 1'b0;
   endtask

   // Presents one request, waits (bounded) for in_ready, and returns just
   // after the accepting edge.
   task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
      int n;
      in_mnem   = m;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_shamt  = sh;
      in_imm    = imm;
      in_target = tgt;
      in_last   = last;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick;
         n++;
      end
      check("send_ready", 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic expect_write(input string tag);
      logic [ADDR_W+32-1:0] e;
      check({tag, "_q"}, 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_we"},   32'(im_we),    32'd1);
      check({tag, "_addr"}, 32'(im_addr),  32'(e[ADDR_W+31:32]));
      check({tag, "_data"}, im_wdata,      e[31:0]);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
      in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_imm = '0; in_target = '0; in_last = 1'b0; im_ack = 1'b1;
      tick;
      tick;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we",    32'(im_we),    32'd0);
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_done",  32'(done),     32'd0);
      check("rst_err",   32'(err),      32'd0);
      check("rst_addr",  32'(im_addr),  32'd0);
      check("rst_data",  im_wdata,      32'd0);
      check("rst_count", 32'(count),    32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick;

      // ADD with shamt masked, single-word program
      pulse_start(12'h100);
      check("t1_ready", 32'(in_ready), 32'd1);
      check("t1_busy",  32'(busy),     32'd1);
      push_exp(12'h100, 32'h00221820);
      send(6'(MN_ADD), 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b1);
      expect_write("t1_add");
      check("t1_ready_w", 32'(in_ready), 32'd0);
      tick;
      check("t1_done",  32'(done),    32'd1);
      check("t1_count", 32'(count),   32'd1);
      check("t1_addr",  32'(im_addr), 32'h104);
      tick;
      check("t1_done_off", 32'(done), 32'd0);
      check("t1_count_hold", 32'(count), 32'd1);

      // LW / BEQ / J program; start while in ACCEPT is ignored
      pulse_start(12'h100);
      pulse_start(12'h300);
      check("t2_start_ign", 32'(im_addr), 32'h100);
      check("t2_count0",    32'(count),   32'd0);
      push_exp(12'h100, 32'h8FA90004);
      send(6'(MN_LW), 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
      expect_write("t2_lw");
      tick;
      push_exp(12'h104, 32'h1022FFFF);
      send(6'(MN_BEQ), 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
      expect_write("t2_beq");
      tick;
      push_exp(12'h108, 32'h08100000);
      send(6'(MN_J), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1);
      expect_write("t2_j");
      tick;
      check("t2_done",  32'(done),    32'd1);
      check("t2_count", 32'(count),   32'd3);
      tick;
      check("t2_done_once", 32'(done), 32'd0);
      check("t2_count_hold", 32'(count), 32'd3);
      check("t2_addr_hold",  32'(im_addr), 32'h10C);

      // Shift/JR/LUI masking, base low bits forced, then a stalled write
      pulse_start(12'h203);
      check("t3_base", 32'(im_addr), 32'h200);
      push_exp(12'h200, 32'h00052080);
      send(6'(MN_SLL), 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0, 1'b0);
      expect_write("t3_sll");
      tick;
      push_exp(12'h204, 32'h03E00008);
      send(6'(MN_JR), 5'd31, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0, 1'b0);
      expect_write("t3_jr");
      tick;
      push_exp(12'h208, 32'h3C08ABCD);
      send(6'(MN_LUI), 5'd5, 5'd8, 5'd0, 5'd0, 16'hABCD, 26'h0, 1'b0);
      expect_write("t3_lui");
      tick;
      im_ack = 1'b0;
      push_exp(12'h20C, 32'h34641234);
      send(6'(MN_ORI), 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
      expect_write("t3_ori");
      for (int i = 0; i < 5; i++) begin
         check("stall_we",    32'(im_we),    32'd1);
         check("stall_addr",  32'(im_addr),  32'h20C);
         check("stall_data",  im_wdata,      32'h34641234);
         check("stall_ready", 32'(in_ready), 32'd0);
         check("stall_count", 32'(count),    32'd3);
         tick;
      end
      im_ack = 1'b1;
      tick;
      check("t3_done",  32'(done),    32'd1);
      check("t3_count", 32'(count),   32'd4);
      check("t3_addr",  32'(im_addr), 32'h210);
      tick;

      // Illegal mnemonics: no write, sticky err, done on last
      pulse_start(12'h040);
      send(6'd33, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
      check("t4_ill_ready", 32'(in_ready), 32'd1);
      check("t4_ill_we",    32'(im_we),    32'd0);
      check("t4_ill_err",   32'(err),      32'd1);
      send(6'h3F, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b1);
      check("t4_done",  32'(done),    32'd1);
      check("t4_we",    32'(im_we),   32'd0);
      check("t4_err",   32'(err),     32'd1);
      check("t4_addr",  32'(im_addr), 32'h040);
      check("t4_count", 32'(count),   32'd0);
      tick;
      check("t4_done_off", 32'(done), 32'd0);
      check("t4_err_sticky", 32'(err), 32'd1);
      pulse_start(12'h080);
      check("t4_err_clr", 32'(err),     32'd0);
      check("t4_addr2",   32'(im_addr), 32'h080);

      // Reset during a stalled write
      im_ack = 1'b0;
      send(6'(MN_ADDU), 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
      check("t5_we_pre", 32'(im_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_we",    32'(im_we),    32'd0);
      check("t5_ready", 32'(in_ready), 32'd0);
      check("t5_busy",  32'(busy),     32'd0);
      check("t5_addr",  32'(im_addr),  32'd0);
      check("t5_data",  im_wdata,      32'd0);
      check("t5_count", 32'(count),    32'd0);
      check("t5_err",   32'(err),      32'd0);
      tick;
      rst = 1'b0;
      im_ack = 1'b1;
      tick;

      // Address wrap from 0xFFC
      pulse_start(12'hFFC);
      push_exp(12'hFFC, 32'h00221820);
      send(6'(MN_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      expect_write("t6_add");
      tick;
      push_exp(12'h000, 32'h00853026);
      send(6'(MN_XOR), 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
      expect_write("t6_xor");
      tick;
      check("t6_done",  32'(done),    32'd1);
      check("t6_count", 32'(count),   32'd2);
      check("t6_addr",  32'(im_addr), 32'h004);
      tick;
      check("t6_idle", 32'(dbg_state), 32'(ST_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
